// File: rtl/alu_pkg.sv
// Purpose: shared ALU constants for the pipelined add/sub path (opcode encoding, default sizes).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  // addsubin encoding
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Default operand width and bits handled per pipeline stage
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 16;

endpackage

// File: rtl/addsub_chunk_stage.sv
// Purpose: one CHUNK-bit ripple slice of the pipelined adder; registers sum, carry and valid.
// Latency: 1 cycle.
// Backpressure: holds all registers while advance is low (global stall driven by the top).
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   advance       pipeline shift enable shared by every stage
//   op_vld        valid bit travelling with this slice's operands
//   a, b, cin     slice operands (b already conditionally inverted) and carry in
//   sum, cout     registered slice sum and carry out
//   sum_vld       registered valid bit
module addsub_chunk_stage
  import alu_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             op_vld,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             sum_vld
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= '0;
      cout    <= 1'b0;
      sum_vld <= 1'b0;
    end else if (advance) begin
      sum     <= total[CHUNK-1:0];
      cout    <= total[CHUNK];
      sum_vld <= op_vld;
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Purpose: pipelined two's-complement add/sub split into WIDTH/CHUNK registered ripple stages.
// Latency: STAGES = WIDTH/CHUNK cycles from accept to out_valid.
// Backpressure: global stall; every stage holds while out_valid && !out_ready, in_ready follows.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_valid, in_ready            operand handshake (in_ready is combinational)
//   input1, input2, addsubin      operand A, operand B, 0 = A+B / 1 = A-B
//   out_valid, out_ready          result handshake
//   out, carry_out, overflow, zero  result and flags (carry_out = no-borrow on subtract)
//
// Build option: define ADDSUB_SATURATE_EN to clamp signed overflow to the
// most positive / most negative value instead of wrapping.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             addsubin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  // WIDTH must be a multiple of CHUNK.
  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw;
  logic             sign_a;
  logic             sign_b;
  logic             ovf;

  // Per-stage operands (after skew), chain inputs and registered outputs
  logic [CHUNK-1:0] a_op      [STAGES];
  logic [CHUNK-1:0] b_op      [STAGES];
  logic             cin_chain [STAGES];
  logic             vld_chain [STAGES];
  logic [CHUNK-1:0] st_sum    [STAGES];
  logic             st_cy     [STAGES];
  logic             st_vld    [STAGES];
  logic [CHUNK-1:0] res_chunk [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is A + ~B + 1; the +1 enters as stage 0 carry in.
  assign b_eff = (addsubin == OP_SUB) ? ~input2 : input2;

  for (genvar j = 0; j < STAGES; j++) begin : g_stage

    if (j == 0) begin : g_direct
      assign a_op[j]      = input1[CHUNK-1:0];
      assign b_op[j]      = b_eff[CHUNK-1:0];
      assign cin_chain[j] = addsubin;
      assign vld_chain[j] = in_valid;
    end else begin : g_skew
      // Chunk j waits j cycles so it meets the carry coming out of stage j-1.
      logic [CHUNK-1:0] a_sk [j];
      logic [CHUNK-1:0] b_sk [j];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < j; d++) begin
            a_sk[d] <= '0;
            b_sk[d] <= '0;
          end
        end else if (advance) begin
          a_sk[0] <= input1[j*CHUNK +: CHUNK];
          b_sk[0] <= b_eff[j*CHUNK +: CHUNK];
          for (int d = 1; d < j; d++) begin
            a_sk[d] <= a_sk[d-1];
            b_sk[d] <= b_sk[d-1];
          end
        end
      end

      assign a_op[j]      = a_sk[j-1];
      assign b_op[j]      = b_sk[j-1];
      assign cin_chain[j] = st_cy[j-1];
      assign vld_chain[j] = st_vld[j-1];
    end

    addsub_chunk_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .op_vld  (vld_chain[j]),
      .a       (a_op[j]),
      .b       (b_op[j]),
      .cin     (cin_chain[j]),
      .sum     (st_sum[j]),
      .cout    (st_cy[j]),
      .sum_vld (st_vld[j])
    );

    if (j == STAGES - 1) begin : g_top
      assign res_chunk[j] = st_sum[j];
    end else begin : g_align
      // Lower chunks finish early; delay them until the top chunk lands.
      localparam int D = STAGES - 1 - j;
      logic [CHUNK-1:0] r_dl [D];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < D; d++) begin
            r_dl[d] <= '0;
          end
        end else if (advance) begin
          r_dl[0] <= st_sum[j];
          for (int d = 1; d < D; d++) begin
            r_dl[d] <= r_dl[d-1];
          end
        end
      end

      assign res_chunk[j] = r_dl[D-1];
    end

    assign raw[j*CHUNK +: CHUNK] = res_chunk[j];
  end

  // Operand sign bits captured alongside the top chunk for the overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (advance) begin
      sign_a <= a_op[STAGES-1][CHUNK-1];
      sign_b <= b_op[STAGES-1][CHUNK-1];
    end
  end

  assign ovf = (sign_a == sign_b) && (raw[WIDTH-1] != sign_a);

`ifdef ADDSUB_SATURATE_EN
  // Positive overflow only happens with A >= 0, negative only with A < 0.
  assign out = ovf ? {sign_a, {(WIDTH-1){!sign_a}}} : raw;
`else
  assign out = raw;
`endif

  assign out_valid = st_vld[STAGES-1];
  assign carry_out = st_cy[STAGES-1];
  assign overflow  = ovf;
  // Gated by valid so the flag reads 0 after reset rather than "result is 0".
  assign zero      = out_valid && (out == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Purpose: self-checking bench for pipelined_addsub (32/16 and 64/16 configurations).
// Latency: n/a.
// Backpressure: n/a.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        in_valid, in_ready, addsubin, out_valid, out_ready;
  logic        carry_out, overflow, zero;
  logic [31:0] input1, input2, out;

  logic        v64, r64, s64, ov64, ordy64, c64, o64, z64;
  logic [63:0] a64, b64, out64;

  pipelined_addsub #(.WIDTH(32), .CHUNK(16)) u_dut32 (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .input1 (input1), .input2 (input2), .addsubin (addsubin),
    .out_valid (out_valid), .out_ready (out_ready),
    .out (out), .carry_out (carry_out), .overflow (overflow), .zero (zero)
  );

  pipelined_addsub #(.WIDTH(64), .CHUNK(16)) u_dut64 (
    .clk (clk), .rst (rst),
    .in_valid (v64), .in_ready (r64),
    .input1 (a64), .input2 (b64), .addsubin (s64),
    .out_valid (ov64), .out_ready (ordy64),
    .out (out64), .carry_out (c64), .overflow (o64), .zero (z64)
  );

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          acc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          n_emit = 0;
  exp_t        q32[$];
  logic [63:0] emits[$];
  logic [63:0] last_out;
  logic        last_c, last_v, last_z, last_acc, last_in_ready;
  int          last_lat;

  // Reference: unsigned arithmetic for result/carry, wide signed arithmetic for overflow.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input int w);
    exp_t               e;
    logic [63:0]        mask, ua, ub;
    logic [64:0]        usum;
    logic signed [66:0] pw, sa, sb, ss, smax, smin;
    pw   = 67'sd1 <<< w;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ua   = a & mask;
    ub   = b & mask;
    usum = sub ? ({1'b0, ua} - {1'b0, ub}) : ({1'b0, ua} + {1'b0, ub});
    e.c  = sub ? (ua >= ub) : usum[w];
    sa   = ua[w-1] ? ($signed({3'b000, ua}) - pw) : $signed({3'b000, ua});
    sb   = ub[w-1] ? ($signed({3'b000, ub}) - pw) : $signed({3'b000, ub});
    ss   = sub ? (sa - sb) : (sa + sb);
    smax = (pw >>> 1) - 67'sd1;
    smin = -(pw >>> 1);
    e.v  = (ss > smax) || (ss < smin);
    e.res = usum[63:0] & mask;
`ifdef ADDSUB_SATURATE_EN
    if (ss > smax)      e.res = smax[63:0] & mask;
    else if (ss < smin) e.res = smin[63:0] & mask;
`endif
    e.z   = (e.res == 64'd0);
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle on the 32-bit DUT: drive, sample mid-cycle, score transfers, clock.
  task automatic cyc32(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic ordy);
    exp_t e;
    in_valid = v; input1 = a; input2 = b; addsubin = s; out_ready = ordy;
    #2;
    last_in_ready = in_ready;
    last_acc      = 1'b0;
    if (!rst) begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        chk("emit_expected", q32.size() != 0, 1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          chk("out", out, e.res);
          chk("carry_out", carry_out, e.c);
          chk("overflow", overflow, e.v);
          chk("zero", zero, e.z);
          last_out = out; last_c = carry_out; last_v = overflow; last_z = zero;
          last_lat = cycle - e.acc;
          emits.push_back(out);
          n_emit++;
        end
      end
      if (in_valid && in_ready) begin
        e     = model(a, b, s, 32);
        e.acc = cycle;
        q32.push_back(e);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    cycle++;
    #1;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n = 0;
    do begin
      cyc32(1'b1, a, b, s, 1'b1);
      n++;
    end while (!last_acc && n < 20);
    chk("accept_timeout", last_acc, 1);
  endtask

  task automatic wait_emit32();
    int start = n_emit;
    int n = 0;
    while (n_emit == start && n < 20) begin
      cyc32(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      n++;
    end
    chk("emit_timeout", n_emit != start, 1);
  endtask

  task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic s);
    send32(a, b, s);
    wait_emit32();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, n0, lat;
    exp_t        e;
    logic [31:0] ra, rb;

    rst = 1'b1;
    in_valid = 1'b0; input1 = '0; input2 = '0; addsubin = 1'b0; out_ready = 1'b1;
    v64 = 1'b0; a64 = '0; b64 = '0; s64 = 1'b0; ordy64 = 1'b1;
    @(posedge clk); #1;
    cyc32(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    cyc32(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid64", ov64, 0);
    rst = 1'b0;

    // Inter-chunk carry
    run_op32(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    chk("carry_chain_out", last_out, 64'h0001_0000);
    chk("carry_chain_lat", last_lat, 2);
    chk("carry_chain_c", last_c, 0);
    chk("carry_chain_v", last_v, 0);
    chk("carry_chain_z", last_z, 0);

    // Subtraction with and without borrow, and a zero result
    run_op32(32'd5, 32'd7, 1'b1);
    chk("sub_borrow_out", last_out, 64'hFFFF_FFFE);
    chk("sub_borrow_c", last_c, 0);
    chk("sub_borrow_v", last_v, 0);
    run_op32(32'd7, 32'd5, 1'b1);
    chk("sub_nob_out", last_out, 64'd2);
    chk("sub_nob_c", last_c, 1);
    run_op32(32'd5, 32'd5, 1'b1);
    chk("sub_zero_out", last_out, 64'd0);
    chk("sub_zero_z", last_z, 1);

    // Signed overflow
    run_op32(32'h7FFF_FFFF, 32'd1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    chk("ovf_pos_out", last_out, 64'h7FFF_FFFF);
`else
    chk("ovf_pos_out", last_out, 64'h8000_0000);
`endif
    chk("ovf_pos_v", last_v, 1);
    run_op32(32'h8000_0000, 32'd1, 1'b1);
`ifdef ADDSUB_SATURATE_EN
    chk("ovf_neg_out", last_out, 64'h8000_0000);
`else
    chk("ovf_neg_out", last_out, 64'h7FFF_FFFF);
`endif
    chk("ovf_neg_v", last_v, 1);
    chk("ovf_neg_c", last_c, 1);

    // Backpressure: back-to-back ops, consumer stalls for 3 cycles
    emits.delete();
    cyc32(1'b1, 32'd1, 32'd1, 1'b0, 1'b1);
    chk("bp_acc1", last_acc, 1);
    cyc32(1'b1, 32'd2, 32'd2, 1'b0, 1'b1);
    chk("bp_acc2", last_acc, 1);
    for (int i = 0; i < 3; i++) begin
      cyc32(1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
      chk("bp_stall_in_ready", last_in_ready, 0);
      chk("bp_stall_out_valid", out_valid, 1);
    end
    send32(32'd3, 32'd3, 1'b0);
    send32(32'd4, 32'd4, 1'b0);
    n = 0;
    while (q32.size() != 0 && n < 20) begin
      cyc32(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      n++;
    end
    chk("bp_count", emits.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < emits.size()) chk("bp_order", emits[i], 64'(2 * (i + 1)));
    end

    // Reset mid-flight discards in-flight ops
    cyc32(1'b1, 32'd10, 32'd10, 1'b0, 1'b1);
    cyc32(1'b1, 32'd20, 32'd20, 1'b0, 1'b1);
    rst = 1'b1;
    cyc32(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    rst = 1'b0;
    q32.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_carry", carry_out, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_zero", zero, 0);
    n0 = n_emit;
    repeat (4) cyc32(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("mid_rst_no_ghost", n_emit - n0, 0);
    run_op32(32'd1, 32'd2, 1'b0);
    chk("post_rst_out", last_out, 64'd3);
    chk("post_rst_lat", last_lat, 2);

    // Random traffic with random consumer stalls
    for (int i = 0; i < 400; i++) begin
      ra = pick();
      rb = pick();
      cyc32($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0);
    end
    n = 0;
    while (q32.size() != 0 && n < 20) begin
      cyc32(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      n++;
    end
    chk("rand_drained", q32.size(), 0);

    // Wide configuration: latency 4
    e   = model(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64);
    v64 = 1'b1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'd1; s64 = 1'b0;
    #2;
    chk("w64_in_ready", r64, 1);
    @(posedge clk); #1;
    v64 = 1'b0;
    lat = 1;
    #1;
    while (!ov64 && lat < 10) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("w64_lat", lat, 4);
    chk("w64_out", out64, 64'd0);
    chk("w64_out_model", out64, e.res);
    chk("w64_carry", c64, 1);
    chk("w64_zero", z64, 1);
    chk("w64_overflow", o64, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
